// File: rtl/network_sequencer_if.sv
// Bundle of the two buses that the sequencer drives.
// The weight ROM read port carries an address strobe out and data/valid back.
// The MAC stream carries clear/enable/last/weight out and the ready handshake back.
// The sequencer uses the master modport; the ROM and MAC side use the slave modport.
interface network_sequencer_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic                rom_rd;
   logic [ADDR_W-1:0]   rom_addr;
   logic [0:DATA_W-1]   rom_data;
   logic                rom_valid;
   logic                mac_ready;
   logic                mac_clr;
   logic                mac_en;
   logic [0:DATA_W-1]   mac_weight;
   logic                mac_last;

   modport master (
      output rom_rd,
      output rom_addr,
      input  rom_data,
      input  rom_valid,
      input  mac_ready,
      output mac_clr,
      output mac_en,
      output mac_weight,
      output mac_last
   );

   modport slave (
      input  rom_rd,
      input  rom_addr,
      output rom_data,
      output rom_valid,
      output mac_ready,
      input  mac_clr,
      input  mac_en,
      input  mac_weight,
      input  mac_last
   );
endinterface

// File: rtl/network_sequencer.sv
// Sequences one forward pass of the network: for every layer, every neuron
// and every input it fetches one weight word from the weight ROM and streams
// it into the shared MAC datapath, clearing the accumulator at the start of
// each neuron and flagging the last input of each neuron.
// Weights are laid out contiguously from BASE_ADDR with no gaps between
// neurons or layers; the address counter wraps modulo 2**ADDR_W.
// A ROM read that is not answered within TIMEOUT cycles aborts the pass.
module network_sequencer #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int N_INPUTS  = 16,
   parameter int N_NEURONS = 8,
   parameter int N_LAYERS  = 2,
   parameter int BASE_ADDR = 0,
   parameter int TIMEOUT   = 15
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   network_sequencer_if.master        bus,
   output logic [7:0]                 layer_idx,
   output logic [7:0]                 neuron_idx,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_WAIT,
      S_ACCUM,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);
   localparam logic [15:0]       LAST_INPUT  = 16'(N_INPUTS - 1);
   localparam logic [7:0]        LAST_NEURON = 8'(N_NEURONS - 1);
   localparam logic [7:0]        LAST_LAYER  = 8'(N_LAYERS - 1);
   localparam logic [15:0]       LAST_WAIT   = 16'(TIMEOUT - 1);

   state_t              state;
   logic [15:0]         input_cnt;
   logic [15:0]         wait_cnt;
   logic [ADDR_W-1:0]   addr_cnt;
   logic [0:DATA_W-1]   weight_q;
   logic                rom_rd_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic                mac_clr_q;
   logic                mac_en_q;
   logic                mac_last_q;

   assign bus.rom_rd     = rom_rd_q;
   assign bus.rom_addr   = rom_addr_q;
   assign bus.mac_clr    = mac_clr_q;
   assign bus.mac_en     = mac_en_q;
   assign bus.mac_weight = weight_q;
   assign bus.mac_last   = mac_last_q;

   // Pass controller: every output is registered and set on the edge that
   // enters the state it belongs to, so rom_rd/mac_clr are exactly one cycle
   // long and mac_en/mac_weight stay put until the MAC accepts the weight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         input_cnt  <= '0;
         wait_cnt   <= '0;
         addr_cnt   <= BASE;
         weight_q   <= '0;
         rom_rd_q   <= 1'b0;
         rom_addr_q <= '0;
         mac_clr_q  <= 1'b0;
         mac_en_q   <= 1'b0;
         mac_last_q <= 1'b0;
         layer_idx  <= '0;
         neuron_idx <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done      <= 1'b0;
         err       <= 1'b0;
         rom_rd_q  <= 1'b0;
         mac_clr_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_CLEAR;
                  mac_clr_q  <= 1'b1;
                  busy       <= 1'b1;
                  layer_idx  <= '0;
                  neuron_idx <= '0;
                  input_cnt  <= '0;
                  addr_cnt   <= BASE;
               end
            end
            S_CLEAR: begin
               state      <= S_FETCH;
               rom_rd_q   <= 1'b1;
               rom_addr_q <= addr_cnt;
            end
            S_FETCH: begin
               state    <= S_WAIT;
               addr_cnt <= addr_cnt + 1'b1;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               if (bus.rom_valid) begin
                  state      <= S_ACCUM;
                  weight_q   <= bus.rom_data;
                  mac_en_q   <= 1'b1;
                  mac_last_q <= (input_cnt == LAST_INPUT);
               end else if (wait_cnt == LAST_WAIT) begin
                  state <= S_IDLE;
                  err   <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_ACCUM: begin
               if (bus.mac_ready) begin
                  mac_en_q   <= 1'b0;
                  mac_last_q <= 1'b0;
                  if (input_cnt != LAST_INPUT) begin
                     input_cnt  <= input_cnt + 1'b1;
                     state      <= S_FETCH;
                     rom_rd_q   <= 1'b1;
                     rom_addr_q <= addr_cnt;
                  end else begin
                     input_cnt <= '0;
                     if (neuron_idx != LAST_NEURON) begin
                        neuron_idx <= neuron_idx + 1'b1;
                        state      <= S_CLEAR;
                        mac_clr_q  <= 1'b1;
                     end else if (layer_idx != LAST_LAYER) begin
                        layer_idx  <= layer_idx + 1'b1;
                        neuron_idx <= '0;
                        state      <= S_CLEAR;
                        mac_clr_q  <= 1'b1;
                     end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_network_sequencer.sv
// Self-checking bench for network_sequencer.
// Two instances: a small single-layer configuration with a ROM that returns
// its address as data, and a two-layer configuration with a 3-bit wrapping
// address space, random ROM latency and random MAC back-pressure.
// A behavioural model derives the expected address, weight, last flag,
// layer/neuron index and done cycle of every weight from plain arithmetic.
module tb_network_sequencer;

   localparam int A_AW = 10, A_NI = 4, A_NN = 2, A_NL = 1, A_BASE = 0, A_TO = 15;
   localparam int B_AW = 3,  B_NI = 4, B_NN = 2, B_NL = 2, B_BASE = 6, B_TO = 4;

   typedef struct packed {
      logic [31:0] w;
      logic        last;
      logic [7:0]  layer;
      logic [7:0]  neuron;
   } acc_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, start_b;
   logic        sel;
   logic        rv;
   logic        mr;
   logic [31:0] rd_data;

   logic [7:0]  layer_a, neuron_a, layer_b, neuron_b;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

   int          checks, passed;

   logic [9:0]  rd_addrs[$];
   acc_t        acc_q[$];
   int          clr_cnt, en_w2, done_cyc, err_cyc, exp_cycles, rom_cnt, stall_left;
   logic        busy0, busy_end, stop_hit;
   logic [9:0]  pend_addr;

   network_sequencer_if #(.ADDR_W(A_AW), .DATA_W(32)) if_a ();
   network_sequencer_if #(.ADDR_W(B_AW), .DATA_W(32)) if_b ();

   network_sequencer #(
      .ADDR_W(A_AW), .DATA_W(32), .N_INPUTS(A_NI), .N_NEURONS(A_NN),
      .N_LAYERS(A_NL), .BASE_ADDR(A_BASE), .TIMEOUT(A_TO)
   ) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .bus(if_a),
      .layer_idx(layer_a), .neuron_idx(neuron_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );

   network_sequencer #(
      .ADDR_W(B_AW), .DATA_W(32), .N_INPUTS(B_NI), .N_NEURONS(B_NN),
      .N_LAYERS(B_NL), .BASE_ADDR(B_BASE), .TIMEOUT(B_TO)
   ) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .bus(if_b),
      .layer_idx(layer_b), .neuron_idx(neuron_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   assign if_a.rom_valid = rv & ~sel;
   assign if_a.rom_data  = rd_data;
   assign if_a.mac_ready = mr & ~sel;
   assign if_b.rom_valid = rv & sel;
   assign if_b.rom_data  = rd_data;
   assign if_b.mac_ready = mr & sel;

   wire        o_rd     = sel ? if_b.rom_rd : if_a.rom_rd;
   wire [9:0]  o_addr   = sel ? {7'd0, if_b.rom_addr} : if_a.rom_addr;
   wire        o_clr    = sel ? if_b.mac_clr : if_a.mac_clr;
   wire        o_en     = sel ? if_b.mac_en : if_a.mac_en;
   wire [31:0] o_w      = sel ? if_b.mac_weight : if_a.mac_weight;
   wire        o_last   = sel ? if_b.mac_last : if_a.mac_last;
   wire [7:0]  o_layer  = sel ? layer_b : layer_a;
   wire [7:0]  o_neuron = sel ? neuron_b : neuron_a;
   wire        o_busy   = sel ? busy_b : busy_a;
   wire        o_done   = sel ? done_b : done_a;
   wire        o_err    = sel ? err_b : err_a;

   wire [64:0] snap_a = {if_a.rom_rd, if_a.rom_addr, if_a.mac_clr, if_a.mac_en, if_a.mac_weight,
                         if_a.mac_last, layer_a, neuron_a, busy_a, done_a, err_a};
   wire [57:0] snap_b = {if_b.rom_rd, if_b.rom_addr, if_b.mac_clr, if_b.mac_en, if_b.mac_weight,
                         if_b.mac_last, layer_b, neuron_b, busy_b, done_b, err_b};

   // ROM contents: instance A returns its address, instance B a scrambled word
   function automatic logic [31:0] rom_word(input logic [9:0] a);
      if (sel) return ((32'(a) + 32'd1) * 32'h0100_0193) ^ 32'h5A5A_0000;
      return 32'(a);
   endfunction

   function automatic logic [9:0] model_addr(input int k);
      if (sel) return 10'((B_BASE + k) % (1 << B_AW));
      return 10'((A_BASE + k) % (1 << A_AW));
   endfunction

   function automatic acc_t model_acc(input int k);
      int   ni = sel ? B_NI : A_NI;
      int   nn = sel ? B_NN : A_NN;
      int   g  = k / ni;
      acc_t r;
      r.w      = rom_word(model_addr(k));
      r.last   = (k % ni == ni - 1);
      r.layer  = 8'(g / nn);
      r.neuron = 8'(g % nn);
      return r;
   endfunction

   // Starts a pass on the selected instance and plays ROM and MAC for it,
   // recording every read address and accepted weight until done/err/stop.
   // ready_mode: 0 always ready, 1 stall weight 2 three cycles, 2 random.
   // lat_mode:   0 ROM never answers, 1 one-cycle latency, 2 random 1..TIMEOUT.
   task automatic collect(input int max_cyc, input int ready_mode, input int lat_mode,
                          input int restart_at, input bit stop_n1);
      int lat;
      rd_addrs.delete();
      acc_q.delete();
      clr_cnt = 0; en_w2 = 0; done_cyc = -1; err_cyc = -1; exp_cycles = 0;
      rom_cnt = 0; stall_left = 3; busy0 = 1'b0; busy_end = 1'b1; stop_hit = 1'b0;
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      rv = 1'b0;
      mr = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         start_a = (!sel && i == restart_at);
         start_b = (sel && i == restart_at);
         if (i == 0) busy0 = o_busy;
         if (o_done) begin done_cyc = i; busy_end = o_busy; break; end
         if (o_err) begin err_cyc = i; busy_end = o_busy; break; end
         if (stop_n1 && o_en && o_neuron == 8'd1) begin stop_hit = 1'b1; break; end
         if (o_clr) clr_cnt++;
         rv = 1'b0;
         if (rom_cnt > 0) begin
            rom_cnt--;
            if (rom_cnt == 0) begin rv = 1'b1; rd_data = rom_word(pend_addr); end
         end
         if (o_rd) begin
            rd_addrs.push_back(o_addr);
            pend_addr = o_addr;
            lat = (lat_mode == 2) ? int'($urandom_range(1, sel ? B_TO : A_TO)) : 1;
            if (lat_mode != 0) rom_cnt = lat;
            exp_cycles += 2 + lat;
         end
         mr = 1'b1;
         if (o_en) begin
            if (o_w == 32'd2) en_w2++;
            if (ready_mode == 1 && o_w == 32'd2 && stall_left > 0) begin
               mr = 1'b0;
               stall_left--;
            end else if (ready_mode == 2 && $urandom_range(0, 2) == 0) begin
               mr = 1'b0;
            end
            if (mr) acc_q.push_back({o_w, o_last, o_layer, o_neuron});
            else exp_cycles++;
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
      rv = 1'b0;
      mr = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (snap_a !== 65'd0) $display("[TB] FAIL reset_outputs_a: got %h expected 0", snap_a);
      else passed++;
      checks++;
      if (snap_b !== 58'd0) $display("[TB] FAIL reset_outputs_b: got %h expected 0", snap_b);
      else passed++;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_a, if_a.rom_rd, if_a.mac_clr} !== 3'b000)
         $display("[TB] FAIL idle_no_start: got %b expected 000", {busy_a, if_a.rom_rd, if_a.mac_clr});
      else passed++;
   endtask

   task automatic test_basic();
      int nw = A_NI * A_NN * A_NL;
      sel = 1'b0;
      collect(80, 0, 1, -1, 1'b0);
      checks++;
      if (rd_addrs.size() !== nw || acc_q.size() !== nw)
         $display("[TB] FAIL basic_count: got rd=%0d acc=%0d expected %0d", rd_addrs.size(), acc_q.size(), nw);
      else passed++;
      for (int k = 0; k < nw && k < rd_addrs.size() && k < acc_q.size(); k++) begin
         checks++;
         if (rd_addrs[k] !== model_addr(k))
            $display("[TB] FAIL basic_addr[%0d]: got %0d expected %0d", k, rd_addrs[k], model_addr(k));
         else passed++;
         checks++;
         if (acc_q[k] !== model_acc(k))
            $display("[TB] FAIL basic_weight[%0d]: got %h expected %h", k, acc_q[k], model_acc(k));
         else passed++;
      end
      checks++;
      if (clr_cnt !== A_NN * A_NL) $display("[TB] FAIL basic_clr: got %0d expected %0d", clr_cnt, A_NN * A_NL);
      else passed++;
      checks++;
      if (done_cyc !== A_NL * A_NN * (1 + 3 * A_NI))
         $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", done_cyc, A_NL * A_NN * (1 + 3 * A_NI));
      else passed++;
      checks++;
      if ({busy0, busy_end} !== 2'b10) $display("[TB] FAIL basic_busy: got %b expected 10", {busy0, busy_end});
      else passed++;
      @(negedge clk);
      checks++;
      if ({o_done, o_busy} !== 2'b00) $display("[TB] FAIL basic_done_pulse: got %b expected 00", {o_done, o_busy});
      else passed++;
   endtask

   task automatic test_backpressure();
      int nw = A_NI * A_NN * A_NL;
      sel = 1'b0;
      collect(80, 1, 1, -1, 1'b0);
      checks++;
      if (rd_addrs.size() !== nw || acc_q.size() !== nw)
         $display("[TB] FAIL stall_count: got rd=%0d acc=%0d expected %0d", rd_addrs.size(), acc_q.size(), nw);
      else passed++;
      for (int k = 0; k < nw && k < rd_addrs.size() && k < acc_q.size(); k++) begin
         checks++;
         if (rd_addrs[k] !== model_addr(k))
            $display("[TB] FAIL stall_addr[%0d]: got %0d expected %0d", k, rd_addrs[k], model_addr(k));
         else passed++;
         checks++;
         if (acc_q[k] !== model_acc(k))
            $display("[TB] FAIL stall_weight[%0d]: got %h expected %h", k, acc_q[k], model_acc(k));
         else passed++;
      end
      checks++;
      if (en_w2 !== 4) $display("[TB] FAIL stall_hold_cycles: got %0d expected 4", en_w2);
      else passed++;
      checks++;
      if (done_cyc !== A_NL * A_NN * (1 + 3 * A_NI) + 3)
         $display("[TB] FAIL stall_done_cycle: got %0d expected %0d", done_cyc, A_NL * A_NN * (1 + 3 * A_NI) + 3);
      else passed++;
   endtask

   task automatic test_timeout();
      sel = 1'b0;
      collect(60, 0, 0, -1, 1'b0);
      checks++;
      if (err_cyc !== 2 + A_TO) $display("[TB] FAIL timeout_err_cycle: got %0d expected %0d", err_cyc, 2 + A_TO);
      else passed++;
      checks++;
      if (done_cyc !== -1) $display("[TB] FAIL timeout_no_done: got %0d expected -1", done_cyc);
      else passed++;
      checks++;
      if (busy_end !== 1'b0 || rd_addrs.size() !== 1)
         $display("[TB] FAIL timeout_state: got busy=%b reads=%0d expected busy=0 reads=1", busy_end, rd_addrs.size());
      else passed++;
      @(negedge clk);
      checks++;
      if ({o_err, o_done} !== 2'b00) $display("[TB] FAIL timeout_err_pulse: got %b expected 00", {o_err, o_done});
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_rd, o_busy, o_clr} !== 3'b000)
         $display("[TB] FAIL timeout_idle: got %b expected 000", {o_rd, o_busy, o_clr});
      else passed++;
   endtask

   task automatic test_restart_ignored();
      int nw = A_NI * A_NN * A_NL;
      sel = 1'b0;
      collect(80, 0, 1, 10, 1'b0);
      checks++;
      if (rd_addrs.size() !== nw || acc_q.size() !== nw)
         $display("[TB] FAIL restart_count: got rd=%0d acc=%0d expected %0d", rd_addrs.size(), acc_q.size(), nw);
      else passed++;
      for (int k = 0; k < nw && k < rd_addrs.size() && k < acc_q.size(); k++) begin
         checks++;
         if (rd_addrs[k] !== model_addr(k))
            $display("[TB] FAIL restart_addr[%0d]: got %0d expected %0d", k, rd_addrs[k], model_addr(k));
         else passed++;
         checks++;
         if (acc_q[k] !== model_acc(k))
            $display("[TB] FAIL restart_weight[%0d]: got %h expected %h", k, acc_q[k], model_acc(k));
         else passed++;
      end
      checks++;
      if (done_cyc !== A_NL * A_NN * (1 + 3 * A_NI))
         $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", done_cyc, A_NL * A_NN * (1 + 3 * A_NI));
      else passed++;
   endtask

   task automatic test_midpass_reset();
      int nw = A_NI * A_NN * A_NL;
      sel = 1'b0;
      collect(80, 0, 1, -1, 1'b1);
      checks++;
      if (stop_hit !== 1'b1) $display("[TB] FAIL midreset_reach_neuron1: got %b expected 1", stop_hit);
      else passed++;
      reset = 1'b0;
      #1;
      checks++;
      if (snap_a !== 65'd0) $display("[TB] FAIL midreset_outputs: got %h expected 0", snap_a);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      collect(80, 0, 1, -1, 1'b0);
      checks++;
      if (rd_addrs.size() !== nw || acc_q.size() !== nw)
         $display("[TB] FAIL midreset_count: got rd=%0d acc=%0d expected %0d", rd_addrs.size(), acc_q.size(), nw);
      else passed++;
      for (int k = 0; k < nw && k < rd_addrs.size() && k < acc_q.size(); k++) begin
         checks++;
         if (rd_addrs[k] !== model_addr(k))
            $display("[TB] FAIL midreset_addr[%0d]: got %0d expected %0d", k, rd_addrs[k], model_addr(k));
         else passed++;
         checks++;
         if (acc_q[k] !== model_acc(k))
            $display("[TB] FAIL midreset_weight[%0d]: got %h expected %h", k, acc_q[k], model_acc(k));
         else passed++;
      end
      checks++;
      if (done_cyc !== A_NL * A_NN * (1 + 3 * A_NI))
         $display("[TB] FAIL midreset_done_cycle: got %0d expected %0d", done_cyc, A_NL * A_NN * (1 + 3 * A_NI));
      else passed++;
   endtask

   task automatic test_wrap_random();
      int nw = B_NI * B_NN * B_NL;
      sel = 1'b1;
      for (int p = 0; p < 3; p++) begin
         collect(400, 2, 2, -1, 1'b0);
         checks++;
         if (rd_addrs.size() !== nw || acc_q.size() !== nw)
            $display("[TB] FAIL rand_count p%0d: got rd=%0d acc=%0d expected %0d", p, rd_addrs.size(), acc_q.size(), nw);
         else passed++;
         for (int k = 0; k < nw && k < rd_addrs.size() && k < acc_q.size(); k++) begin
            checks++;
            if (rd_addrs[k] !== model_addr(k))
               $display("[TB] FAIL rand_addr p%0d[%0d]: got %0d expected %0d", p, k, rd_addrs[k], model_addr(k));
            else passed++;
            checks++;
            if (acc_q[k] !== model_acc(k))
               $display("[TB] FAIL rand_weight p%0d[%0d]: got %h expected %h", p, k, acc_q[k], model_acc(k));
            else passed++;
         end
         checks++;
         if (clr_cnt !== B_NN * B_NL) $display("[TB] FAIL rand_clr p%0d: got %0d expected %0d", p, clr_cnt, B_NN * B_NL);
         else passed++;
         checks++;
         if (done_cyc !== B_NN * B_NL + exp_cycles || err_cyc !== -1)
            $display("[TB] FAIL rand_done_cycle p%0d: got done=%0d err=%0d expected done=%0d err=-1",
                     p, done_cyc, err_cyc, B_NN * B_NL + exp_cycles);
         else passed++;
         checks++;
         if ({busy0, busy_end} !== 2'b10) $display("[TB] FAIL rand_busy p%0d: got %b expected 10", p, {busy0, busy_end});
         else passed++;
      end
   endtask

   // Runs every scenario in order and prints the tally
   initial begin
      checks  = 0;
      passed  = 0;
      sel     = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      rv      = 1'b0;
      mr      = 1'b1;
      rd_data = '0;
      reset   = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_restart_ignored();
      test_midpass_reset();
      test_wrap_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
